// File: rtl/char_motion_ctrl_pkg.sv
// Shared game constants, scene codes and the vertical motion state encoding.
// Also holds the pixel clamp used by every position update.
package char_motion_ctrl_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int TILE     = 32;

    typedef enum logic [1:0] {
        SCN_START = 2'd0,
        SCN_PLAY  = 2'd1,
        SCN_LOSE  = 2'd2,
        SCN_WIN   = 2'd3
    } scene_e;

    typedef enum logic [1:0] {
        V_GROUND = 2'd0,
        V_RISE   = 2'd1,
        V_FALL   = 2'd2
    } vstate_e;

    // Positions are widened to 11-bit signed so a step past either edge clamps instead of wrapping.
    function automatic logic [9:0] clamp_px(input logic signed [10:0] v, input logic [9:0] hi);
        logic [9:0] r;
        if (v < 11'sd0)
            r = '0;
        else if (v > $signed({1'b0, hi}))
            r = hi;
        else
            r = v[9:0];
        return r;
    endfunction

endpackage

// File: rtl/char_motion_ctrl_if.sv
// Per-player control bundle: frame timing, buttons and collision probes in, sprite pose out.
interface char_motion_ctrl_if;

    logic       vsync;
    logic       enable;
    logic       respawn;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic       solid_below;
    logic       solid_above;
    logic       solid_left;
    logic       solid_right;
    logic [9:0] img_x;
    logic [9:0] img_y;
    logic [2:0] frame_idx;
    logic       is_moving;
    logic       face_left;
    logic       airborne;
    logic       game_tick;

    modport master (
        output vsync, enable, respawn, btn_left, btn_right, btn_jump,
               solid_below, solid_above, solid_left, solid_right,
        input  img_x, img_y, frame_idx, is_moving, face_left, airborne, game_tick
    );

    modport slave (
        input  vsync, enable, respawn, btn_left, btn_right, btn_jump,
               solid_below, solid_above, solid_left, solid_right,
        output img_x, img_y, frame_idx, is_moving, face_left, airborne, game_tick
    );

endinterface

// File: rtl/char_motion_ctrl_vsync_tick_gen.sv
// Brings vsync into the clk domain and emits a registered one-clk pulse per rising edge,
// three clocks after the raw vsync rise.
module vsync_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic game_tick
);

    // [1:0] are the synchroniser, [2] holds the previous synchronised level for edge detect
    logic [2:0] vs_pipe_q, vs_pipe_d;
    logic       tick_q, tick_d;

    always_comb begin
        vs_pipe_d = {vs_pipe_q[1:0], vsync};
        tick_d    = vs_pipe_q[1] & ~vs_pipe_q[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_pipe_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            vs_pipe_q <= vs_pipe_d;
            tick_q    <= tick_d;
        end
    end

    assign game_tick = tick_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// One character's per-frame motion: walking with wall/edge clamps, a ground/rise/fall jump FSM
// and a tick-divided idle/walk animation counter.
module char_motion_ctrl
    import char_motion_ctrl_pkg::*;
#(
    parameter int X_INIT      = 32,
    parameter int Y_INIT      = 320,
    parameter int WALK_SPEED  = 2,
    parameter int JUMP_V      = 10,
    parameter int GRAVITY     = 1,
    parameter int VMAX_FALL   = 8,
    parameter int X_MAX       = 608,
    parameter int Y_MAX       = 448,
    parameter int IDLE_FRAMES = 4,
    parameter int WALK_FRAMES = 6,
    parameter int ANIM_DIV    = 8
) (
    input  logic              clk,
    input  logic              rst,
    char_motion_ctrl_if.slave io
);

    localparam logic [9:0]        XI    = 10'(X_INIT);
    localparam logic [9:0]        YI    = 10'(Y_INIT);
    localparam logic [9:0]        XMAX  = 10'(X_MAX);
    localparam logic [9:0]        YMAX  = 10'(Y_MAX);
    localparam logic signed [10:0] WS   = 11'(WALK_SPEED);
    localparam logic [4:0]        JV    = 5'(JUMP_V);
    localparam logic [4:0]        GR    = 5'(GRAVITY);
    localparam logic [4:0]        VMF   = 5'(VMAX_FALL);
    localparam logic [2:0]        WLAST = 3'(WALK_FRAMES - 1);
    localparam logic [2:0]        ILAST = 3'(IDLE_FRAMES - 1);
    localparam int                DW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0]     DLAST = DW'(ANIM_DIV - 1);

    logic          tick, upd;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [4:0]    vy_q, vy_d;
    vstate_e       vst_q, vst_d, vst_nxt;
    logic          face_q, face_d, mov_q, mov_d;
    logic [2:0]    frame_q, frame_d;
    logic [DW-1:0] div_q, div_d;

    logic [9:0]    x_nxt, y_nxt, rise_y, fall_y;
    logic [4:0]    vy_nxt, rise_vy, fall_vsum, fall_vy;
    logic          face_nxt, mov_nxt;
    logic [2:0]    frame_last;

    vsync_tick_gen u_tick (
        .clk       (clk),
        .rst       (rst),
        .vsync     (io.vsync),
        .game_tick (tick)
    );

    assign upd = io.enable & tick;

    always_comb begin
        x_nxt    = x_q;
        face_nxt = face_q;
        if (io.btn_left ^ io.btn_right) begin
            if (io.btn_left) begin
                face_nxt = 1'b1;
                if (!io.solid_left)
                    x_nxt = clamp_px($signed({1'b0, x_q}) - WS, XMAX);
            end else begin
                face_nxt = 1'b0;
                if (!io.solid_right)
                    x_nxt = clamp_px($signed({1'b0, x_q}) + WS, XMAX);
            end
        end
        mov_nxt = (x_nxt != x_q);
    end

    always_comb begin
        rise_y    = clamp_px($signed({1'b0, y_q}) - $signed({6'b0, vy_q}), YMAX);
        rise_vy   = vy_q - GR;
        fall_y    = clamp_px($signed({1'b0, y_q}) + $signed({6'b0, vy_q}), YMAX);
        fall_vsum = vy_q + GR;
        fall_vy   = (fall_vsum > VMF) ? VMF : fall_vsum;
    end

    // Vertical FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vst_q <= V_GROUND;
        else     vst_q <= vst_d;
    end

    // Vertical FSM: next state
    always_comb begin
        vst_nxt = vst_q;
        case (vst_q)
            V_GROUND: begin
                if (io.btn_jump && !io.solid_above) vst_nxt = V_RISE;
                else if (!io.solid_below)           vst_nxt = V_FALL;
            end
            V_RISE: begin
                if (rise_vy == 5'd0 || io.solid_above || rise_y == 10'd0) vst_nxt = V_FALL;
            end
            V_FALL: begin
                if (io.solid_below || y_q == YMAX) vst_nxt = V_GROUND;
            end
            default: vst_nxt = V_GROUND;
        endcase
        vst_d = vst_q;
        if (io.respawn) vst_d = V_GROUND;
        else if (upd)   vst_d = vst_nxt;
    end

    // Vertical FSM: position/velocity outputs
    always_comb begin
        y_nxt  = y_q;
        vy_nxt = vy_q;
        case (vst_q)
            V_GROUND: vy_nxt = (vst_nxt == V_RISE) ? JV : 5'd0;
            V_RISE: begin
                y_nxt  = rise_y;
                vy_nxt = (vst_nxt == V_FALL) ? 5'd0 : rise_vy;
            end
            V_FALL: begin
                if (vst_nxt == V_GROUND) begin
                    y_nxt  = {y_q[9:5], 5'b0};
                    vy_nxt = 5'd0;
                end else begin
                    y_nxt  = fall_y;
                    vy_nxt = fall_vy;
                end
            end
            default: vy_nxt = 5'd0;
        endcase
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        face_d     = face_q;
        mov_d      = mov_q;
        frame_d    = frame_q;
        div_d      = div_q;
        frame_last = mov_nxt ? WLAST : ILAST;
        if (io.respawn) begin
            x_d     = XI;
            y_d     = YI;
            vy_d    = '0;
            face_d  = 1'b0;
            mov_d   = 1'b0;
            frame_d = '0;
            div_d   = '0;
        end else if (upd) begin
            x_d    = x_nxt;
            y_d    = y_nxt;
            vy_d   = vy_nxt;
            face_d = face_nxt;
            mov_d  = mov_nxt;
            // A switch between idle and walk restarts the new animation from its first frame
            if (mov_nxt != mov_q) begin
                frame_d = '0;
                div_d   = '0;
            end else if (div_q == DLAST) begin
                div_d   = '0;
                frame_d = (frame_q == frame_last) ? 3'd0 : frame_q + 3'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= XI;
            y_q     <= YI;
            vy_q    <= '0;
            face_q  <= 1'b0;
            mov_q   <= 1'b0;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            face_q  <= face_d;
            mov_q   <= mov_d;
            frame_q <= frame_d;
            div_q   <= div_d;
        end
    end

    assign io.img_x     = x_q;
    assign io.img_y     = y_q;
    assign io.frame_idx = frame_q;
    assign io.is_moving = mov_q;
    assign io.face_left = face_q;
    assign io.airborne  = (vst_q != V_GROUND);
    assign io.game_tick = tick;

endmodule
